remote_switch_n: RTL and testbench



---
 rtl/remote_switch_n.sv | 145 ++++++++++++++
 tb/tb_remote_switch_n.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/remote_switch_n.sv
// remote_switch_n: IR remote channel selector.
// Synchronises the raw IR line, detects rising edges and accepts at most one
// edge per hold-off window. Each accepted edge steps the led pattern by the
// selected mode (rotate left, rotate right, binary count, ping-pong).
// The accept pulse is exported as `evt` because `event` is a reserved word.
// Optional feature: define REMOTE_SWITCH_FILTER_EN to insert a 3-sample
// majority filter after the synchroniser (single-cycle glitches are rejected,
// edge-to-led latency grows by two cycles).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_HOLD  | hold-off running, cnt counts up, edges are discarded
// S_ARMED | hold-off expired, next rise with en=1 is accepted
module remote_switch_n #(
  parameter int NCH     = 4,
  parameter int HOLDOFF = 12000000,
  parameter int CNT_W   = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  input  logic           en,
  input  logic [1:0]     mode,
  output logic [NCH-1:0] led,
  output logic           evt,
  output logic           armed
);

  typedef enum logic {S_HOLD, S_ARMED} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [NCH-1:0]   LED_ONE   = NCH'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NCH-1:0]   led_n, led_upd;
  logic             dir, dir_n, dir_upd;
  logic             evt_n;

  logic rxd_tmp, rxd_s, rxd_old, rise;
  logic sig;

`ifdef REMOTE_SWITCH_FILTER_EN
  logic [2:0] filt_sr;

  // Majority-of-three shift register behind the synchroniser.
  always_ff @(posedge clk) begin
    if (rst) filt_sr <= 3'b111;
    else     filt_sr <= {filt_sr[1:0], rxd_s};
  end

  assign sig = (filt_sr[0] & filt_sr[1]) | (filt_sr[0] & filt_sr[2]) |
               (filt_sr[1] & filt_sr[2]);
`else
  assign sig = rxd_s;
`endif

  // Two-flop synchroniser and registered rising-edge detect; idle-high reset
  // keeps a line that is already high from producing a spurious rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_tmp <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_old <= 1'b1;
      rise    <= 1'b0;
    end else begin
      rxd_tmp <= rxd;
      rxd_s   <= rxd_tmp;
      rxd_old <= sig;
      rise    <= sig & ~rxd_old;
    end
  end

  // Next led pattern and ping-pong direction for the mode sampled at accept.
  always_comb begin
    led_upd = led;
    dir_upd = dir;
    unique case (mode)
      2'd0: led_upd = (led == '0) ? LED_ONE : {led[NCH-2:0], led[NCH-1]};
      2'd1: led_upd = (led == '0) ? LED_ONE : {led[0], led[NCH-1:1]};
      2'd2: led_upd = led + 1'b1;
      2'd3: begin
        if (led == '0) begin
          led_upd = LED_ONE;
        end else if (!dir && led[NCH-1]) begin
          dir_upd = 1'b1;
          led_upd = {1'b0, led[NCH-1:1]};
        end else if (dir && led[0]) begin
          dir_upd = 1'b0;
          led_upd = {led[NCH-2:0], 1'b0};
        end else if (dir) begin
          led_upd = {1'b0, led[NCH-1:1]};
        end else begin
          led_upd = {led[NCH-2:0], 1'b0};
        end
      end
      default: led_upd = led;
    endcase
  end

  // Hold-off / accept FSM next-state logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    led_n   = led;
    dir_n   = dir;
    evt_n   = 1'b0;
    unique case (state)
      S_HOLD: begin
        if (cnt == HOLD_LAST) state_n = S_ARMED;
        else                  cnt_n   = cnt + 1'b1;
      end
      S_ARMED: begin
        if (rise && en) begin
          led_n   = led_upd;
          dir_n   = dir_upd;
          evt_n   = 1'b1;
          cnt_n   = '0;
          state_n = S_HOLD;
        end
      end
      default: state_n = S_HOLD;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HOLD;
      cnt   <= '0;
      led   <= LED_ONE;
      dir   <= 1'b0;
      evt   <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      led   <= led_n;
      dir   <= dir_n;
      evt   <= evt_n;
      armed <= (state_n == S_ARMED);
    end
  end

endmodule

// File: tb/tb_remote_switch_n.sv
// Testbench for remote_switch_n (NCH=4, HOLDOFF=8). Honours
// REMOTE_SWITCH_FILTER_EN when the design is built with it.
module tb_remote_switch_n;

  localparam int NCH     = 4;
  localparam int HOLDOFF = 8;
  localparam int CNT_W   = 4;

  logic           clk;
  logic           rst;
  logic           rxd;
  logic           en;
  logic [1:0]     mode;
  logic [NCH-1:0] led;
  logic           evt;
  logic           armed;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int   t;
  int   last_acc;
  int   m_led;
  bit   m_dir;
  bit   m_evt;
  bit   m_armed;
  bit   hist[$];

  remote_switch_n #(.NCH(NCH), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .en    (en),
    .mode  (mode),
    .led   (led),
    .evt   (evt),
    .armed (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  function automatic bit maj3(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  // Pattern step from the mode rules, on plain integers.
  task automatic apply_mode(input int md);
    int v;
    v = m_led;
    case (md)
      0: v = (v == 0) ? 1 : ((v * 2) % 16) + (v / 8);
      1: v = (v == 0) ? 1 : (v / 2) + (v % 2) * 8;
      2: v = (v + 1) % 16;
      default: begin
        if (v == 0) v = 1;
        else if (!m_dir && v >= 8) begin m_dir = 1; v = v / 2; end
        else if (m_dir && (v % 2) == 1) begin m_dir = 0; v = (v * 2) % 16; end
        else if (m_dir) v = v / 2;
        else v = (v * 2) % 16;
      end
    endcase
    m_led = v;
  endtask

  // One clock edge of the reference: hist[0] is the rxd sampled at this edge.
  task automatic model_step();
    bit rise_m;
    bit acc;
    t++;
    if (rst) begin
      hist.delete();
      repeat (8) hist.push_back(1'b1);
      m_led = 1; m_dir = 0; m_evt = 0; m_armed = 0; last_acc = t;
      return;
    end
    hist.push_front(rxd);
    void'(hist.pop_back());
`ifdef REMOTE_SWITCH_FILTER_EN
    rise_m = maj3(hist[4], hist[5], hist[6]) && !maj3(hist[5], hist[6], hist[7]);
`else
    rise_m = hist[3] && !hist[4];
`endif
    acc   = m_armed && rise_m && en;
    m_evt = acc;
    if (acc) begin
      last_acc = t;
      apply_mode(int'(mode));
    end
    m_armed = !acc && ((t - last_acc) >= HOLDOFF);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led", 32'(led), 32'(m_led));
    check("evt", 32'(evt), 32'(m_evt));
    check("armed", 32'(armed), 32'(m_armed));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    rxd = 1'b1;
    run(hi);
    rxd = 1'b0;
    run(lo);
  endtask

  initial begin
    t = 0; last_acc = 0; m_led = 1; m_dir = 0; m_evt = 0; m_armed = 0;
    repeat (8) hist.push_back(1'b1);
    rst = 1'b1; rxd = 1'b1; en = 1'b1; mode = 2'd0;

    // reset, line idling high
    do_reset();
    run(7);
    check("armed_before_holdoff", 32'(armed), 32'd0);
    run(1);
    check("armed_after_holdoff", 32'(armed), 32'd1);
    check("led_reset", 32'(led), 32'd1);
    run(4);

    // rotate left, four pulses 12 cycles apart
    rxd = 1'b0; run(3);
    mode = 2'd0;
    for (int i = 0; i < 4; i++) pulse(2, 10);
    check("rotl_wrap", 32'(led), 32'd1);

    // two rises 4 cycles apart: only the first accepted
    pulse(2, 2);
    pulse(2, 12);
    check("holdoff_drop", 32'(led), 32'd2);

    // binary count wrap
    do_reset(); rxd = 1'b0; run(10);
    mode = 2'd2;
    for (int i = 0; i < 14; i++) pulse(2, 10);
    check("count_ones", 32'(led), 32'hf);
    pulse(2, 10);
    check("count_wrap", 32'(led), 32'd0);

    // ping-pong from 0001
    do_reset(); rxd = 1'b0; run(10);
    mode = 2'd3;
    for (int i = 0; i < 6; i++) pulse(2, 10);
    check("pingpong_end", 32'(led), 32'd1);

    // en=0 ignored while armed, then accepted with en=1, then rst after accept
    mode = 2'd0; en = 1'b0;
    pulse(2, 10);
    check("en_low_led", 32'(led), 32'd1);
    check("en_low_armed", 32'(armed), 32'd1);
    en = 1'b1;
    rxd = 1'b1; run(1);
    rxd = 1'b0; run(3);
    check("en_high_led", 32'(led), 32'd2);
    run(1);
    rst = 1'b1; run(1); rst = 1'b0;
    check("rst_led", 32'(led), 32'd1);
    check("rst_armed", 32'(armed), 32'd0);
    run(12);

    // single-cycle glitch (accepted only without the filter)
    pulse(1, 12);
    pulse(3, 12);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      mode = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1; run(1); rst = 1'b0;
      end
      pulse($urandom_range(1, 4), $urandom_range(1, 14));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
